// File: rtl/qpsk_pkg.sv
// Shared QPSK transmit definitions: frame-controller state encoding,
// preamble dibits and default symbol-rate / frame-length constants.
package qpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_TAIL
  } state_e;

  // Preamble alternates 00,11,00,11,... starting with symbol 0
  localparam logic [1:0] PRE_DIBIT_EVEN = 2'b00;
  localparam logic [1:0] PRE_DIBIT_ODD  = 2'b11;

  localparam int unsigned DEF_SPS           = 10;
  localparam int unsigned DEF_PREAMBLE_SYMS = 8;
  localparam int unsigned DEF_PAYLOAD_SYMS  = 16;
  localparam int unsigned DEF_TAIL_SYMS     = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qpsk_frame_ctrl_if.sv
// Bit-source handshake and modulator-facing symbol bus of the frame controller.
interface qpsk_frame_ctrl_if;
  logic start;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic sym_i;
  logic sym_q;
  logic sym_stb;
  logic mod_en;
  logic busy;
  logic frame_done;
  logic underrun;

  // Bit source / frame initiator side
  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, sym_i, sym_q, sym_stb, mod_en, busy, frame_done, underrun
  );

  // Frame controller side
  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, sym_i, sym_q, sym_stb, mod_en, busy, frame_done, underrun
  );
endinterface

// File: rtl/qpsk_sym_timer.sv
// Samples-per-symbol counter: flags the last sample of each symbol period.
module qpsk_sym_timer
  import qpsk_pkg::*;
#(
  parameter int unsigned SPS = DEF_SPS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last_samp
);
  localparam int unsigned W = $clog2(SPS);
  localparam logic [W-1:0] LAST = W'(SPS - 1);

  logic [W-1:0] samp_cnt_q, samp_cnt_d;

  // Next count: restart on symbol load, otherwise advance while enabled
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    if (clr)     samp_cnt_d = '0;
    else if (en) samp_cnt_d = samp_cnt_q + W'(1);
  end

  // Sample counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) samp_cnt_q <= '0;
    else     samp_cnt_q <= samp_cnt_d;
  end

  assign last_samp = (samp_cnt_q == LAST);
endmodule

// File: rtl/qpsk_frame_ctrl.sv
// QPSK frame sequencer: preamble -> payload -> tail, packing serial payload
// bits into I/Q dibits and presenting one symbol every SPS clocks.
module qpsk_frame_ctrl
  import qpsk_pkg::*;
#(
  parameter int unsigned SPS           = DEF_SPS,
  parameter int unsigned PREAMBLE_SYMS = DEF_PREAMBLE_SYMS,
  parameter int unsigned PAYLOAD_SYMS  = DEF_PAYLOAD_SYMS,
  parameter int unsigned TAIL_SYMS     = DEF_TAIL_SYMS
) (
  input logic               clk,
  input logic               rst,
  qpsk_frame_ctrl_if.slave  bus
);
  localparam int unsigned SW = $clog2(max3(PREAMBLE_SYMS, PAYLOAD_SYMS, TAIL_SYMS) + 1);
  localparam logic [SW-1:0] PRE_LAST  = SW'(PREAMBLE_SYMS - 1);
  localparam logic [SW-1:0] PAY_LAST  = SW'(PAYLOAD_SYMS - 1);
  localparam logic [SW-1:0] TAIL_LAST = SW'(TAIL_SYMS - 1);

  state_e        state_q, state_d, nxt_state;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d, nxt_idx;
  logic [1:0]    buf_q, buf_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic          sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic          sym_stb_q, sym_stb_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;
  logic          last_samp, timer_clr, last_in_state, active, bit_ready, accept;

  assign active = (state_q != ST_IDLE);

  // Ready only while payload bits are still needed and the dibit buffer has room
  assign bit_ready = ~buf_cnt_q[1] &
                     ((state_q == ST_PREAMBLE) |
                      ((state_q == ST_PAYLOAD) & (sym_cnt_q != PAY_LAST)));
  assign accept = bus.bit_valid & bit_ready;

  qpsk_sym_timer #(.SPS(SPS)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (active),
    .clr       (timer_clr),
    .last_samp (last_samp)
  );

  // Next-state, symbol load and bit-buffer update
  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    buf_d         = buf_q;
    buf_cnt_d     = buf_cnt_q;
    sym_i_d       = sym_i_q;
    sym_q_d       = sym_q_q;
    sym_stb_d     = 1'b0;
    frame_done_d  = 1'b0;
    underrun_d    = underrun_q;
    timer_clr     = 1'b0;
    nxt_state     = state_q;
    nxt_idx       = sym_cnt_q;
    last_in_state = 1'b0;

    if (accept) begin
      buf_d[buf_cnt_q[0]] = bus.bit_in;
      buf_cnt_d           = buf_cnt_q + 2'd1;
    end

    case (state_q)
      ST_PREAMBLE: last_in_state = (sym_cnt_q == PRE_LAST);
      ST_PAYLOAD:  last_in_state = (sym_cnt_q == PAY_LAST);
      ST_TAIL:     last_in_state = (sym_cnt_q == TAIL_LAST);
      default:     last_in_state = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        state_d            = ST_PREAMBLE;
        sym_cnt_d          = '0;
        {sym_i_d, sym_q_d} = PRE_DIBIT_EVEN;
        sym_stb_d          = 1'b1;
        underrun_d         = 1'b0;
        timer_clr          = 1'b1;
      end
    end else if (last_samp) begin
      timer_clr = 1'b1;
      if (last_in_state) begin
        nxt_idx = '0;
        case (state_q)
          ST_PREAMBLE: nxt_state = ST_PAYLOAD;
          ST_PAYLOAD:  nxt_state = ST_TAIL;
          default:     nxt_state = ST_IDLE;
        endcase
      end else begin
        nxt_idx = sym_cnt_q + 1'b1;
      end
      state_d   = nxt_state;
      sym_cnt_d = nxt_idx;
      sym_stb_d = 1'b1;
      case (nxt_state)
        ST_PREAMBLE: {sym_i_d, sym_q_d} = nxt_idx[0] ? PRE_DIBIT_ODD : PRE_DIBIT_EVEN;
        ST_PAYLOAD: begin
          if (buf_cnt_q == 2'd2) begin
            sym_i_d   = buf_q[0];
            sym_q_d   = buf_q[1];
            buf_cnt_d = '0;
          end else begin
            // Partial bit stays buffered; a same-edge accept appends behind it
            {sym_i_d, sym_q_d} = 2'b00;
            underrun_d         = 1'b1;
          end
        end
        ST_TAIL: {sym_i_d, sym_q_d} = 2'b00;
        default: begin
          {sym_i_d, sym_q_d} = 2'b00;
          sym_stb_d          = 1'b0;
          frame_done_d       = 1'b1;
          buf_cnt_d          = '0;
        end
      endcase
    end
  end

  // State, counters, buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      buf_q        <= '0;
      buf_cnt_q    <= '0;
      sym_i_q      <= 1'b0;
      sym_q_q      <= 1'b0;
      sym_stb_q    <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      buf_q        <= buf_d;
      buf_cnt_q    <= buf_cnt_d;
      sym_i_q      <= sym_i_d;
      sym_q_q      <= sym_q_d;
      sym_stb_q    <= sym_stb_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.sym_i      = sym_i_q;
  assign bus.sym_q      = sym_q_q;
  assign bus.sym_stb    = sym_stb_q;
  assign bus.mod_en     = active;
  assign bus.busy       = active;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Bench for qpsk_frame_ctrl: randomized bit source, frame-level reference
// model feeding a symbol scoreboard, plus per-cycle output comparison.
module tb_qpsk_frame_ctrl;
  localparam int SPS   = 10;
  localparam int NP    = 8;
  localparam int NL    = 16;
  localparam int NT    = 2;
  localparam int TOTAL = (NP + NL + NT) * SPS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpsk_frame_ctrl_if bus();

  qpsk_frame_ctrl #(.SPS(SPS), .PREAMBLE_SYMS(NP), .PAYLOAD_SYMS(NL), .TAIL_SYMS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  bit         m_act;
  int         m_t;      // cycle number within the frame, 1..TOTAL
  bit         m_bits[$];
  bit         m_und, m_stb, m_fd, m_rdy;
  int         m_k;
  logic [1:0] m_sym, m_d;
  logic [1:0] exp_q[$];

  function automatic bit m_ready();
    if (!m_act) return 1'b0;
    return (((m_t - 1) / SPS) < (NP + NL - 1)) && (m_bits.size() < 2);
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_act = 0; m_t = 0; m_bits.delete(); m_und = 0; m_stb = 0; m_fd = 0;
      m_sym = 2'b00; exp_q.delete();
    end else begin
      m_rdy = m_ready();
      m_stb = 0;
      m_fd  = 0;
      if (!m_act) begin
        if (bus.start) begin
          m_act = 1; m_t = 1; m_und = 0; m_stb = 1; m_sym = 2'b00;
          exp_q.push_back(2'b00);
        end
      end else begin
        if (m_t == TOTAL) begin
          m_act = 0; m_fd = 1; m_sym = 2'b00; m_bits.delete(); m_t = 0;
        end else begin
          if (m_t % SPS == 0) begin
            m_k = m_t / SPS;
            if (m_k < NP) m_d = (m_k % 2 == 1) ? 2'b11 : 2'b00;
            else if (m_k < NP + NL) begin
              if (m_bits.size() >= 2) begin
                m_d = {m_bits[0], m_bits[1]};
                void'(m_bits.pop_front());
                void'(m_bits.pop_front());
              end else begin
                m_d = 2'b00;
                m_und = 1;
              end
            end else m_d = 2'b00;
            m_sym = m_d; m_stb = 1;
            exp_q.push_back(m_d);
          end
          if (bus.bit_valid && m_rdy) m_bits.push_back(bus.bit_in);
          m_t++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         cyc;
  int         en_cnt, acc_cnt, stb_cnt;
  int         fd_times[$];
  logic [1:0] obs_syms[$];
  logic [1:0] sb_d;

  function automatic logic [7:0] dut_outs();
    return {bus.busy, bus.mod_en, bus.frame_done, bus.sym_stb,
            bus.bit_ready, bus.underrun, bus.sym_i, bus.sym_q};
  endfunction

  initial forever begin
    @(negedge clk);
    check("outputs", 32'(dut_outs()),
          32'({m_act, m_act, m_fd, m_stb, m_ready(), m_und, m_sym}));
    if (bus.sym_stb === 1'b1) begin
      stb_cnt++;
      obs_syms.push_back({bus.sym_i, bus.sym_q});
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sym_scoreboard: got strobe %b%b expected no strobe at %0t",
                 bus.sym_i, bus.sym_q, $time);
      end else begin
        sb_d = exp_q.pop_front();
        check("sym_scoreboard", 32'({bus.sym_i, bus.sym_q}), 32'(sb_d));
      end
    end
    if (bus.mod_en === 1'b1) en_cnt++;
    if (bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1) acc_cnt++;
    if (bus.frame_done === 1'b1) fd_times.push_back(cyc);
  end

  // ---------------- driver ----------------
  int vmode, vcut, src_mode, src_idx;
  bit src_cur;

  task automatic step();
    bit hs;
    hs = bus.bit_valid && bus.bit_ready;
    @(posedge clk); #1;
    cyc++;
    if (hs) begin
      src_idx++;
      src_cur = (src_mode == 0) ? ((src_idx % 4 == 0) || (src_idx % 4 == 3))
                                : 1'($urandom_range(1));
    end
    bus.bit_in = src_cur;
    case (vmode)
      0:       bus.bit_valid = 1'b1;
      1:       bus.bit_valid = ($urandom_range(3) != 0);
      default: bus.bit_valid = (cyc < vcut);
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start_frame(input int vm, input int sm, input int cut, input bit hold);
    vmode = vm; src_mode = sm; vcut = cut; src_idx = 0;
    src_cur = (sm == 0) ? 1'b1 : 1'($urandom_range(1));
    bus.bit_in = src_cur;
    bus.bit_valid = 1'b1;
    bus.start = 1'b1;
    cyc = 0; en_cnt = 0; acc_cnt = 0; stb_cnt = 0;
    fd_times.delete(); obs_syms.delete();
    step();
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_mod_en_cycles"}, 32'(en_cnt), 32'(TOTAL));
    check({tag, "_frame_done_count"}, 32'(fd_times.size()), 32'd1);
    if (fd_times.size() >= 1) check({tag, "_frame_done_cycle"}, 32'(fd_times[0]), 32'(TOTAL + 1));
    check({tag, "_strobes"}, 32'(stb_cnt), 32'(NP + NL + NT));
  endtask

  initial begin
    bus.start = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    vmode = 0; vcut = 0; src_mode = 0; src_idx = 0; src_cur = 1'b0; cyc = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_outs()), 32'd0);
    rst = 1'b0;
    run(3);
    check("post_reset_idle", 32'(dut_outs()), 32'd0);

    // Nominal frame, bits 1,0,0,1,... always valid
    start_frame(0, 0, 0, 1'b0);
    check("first_strobe_cycle1", 32'(bus.sym_stb), 32'd1);
    run(TOTAL + 5);
    check_frame("nominal");
    check("nominal_bits_accepted", 32'(acc_cnt), 32'(2 * NL));
    if (obs_syms.size() > NP + 1) begin
      check("payload0_dibit", 32'(obs_syms[NP]), 32'(2'b10));
      check("payload1_dibit", 32'(obs_syms[NP + 1]), 32'(2'b01));
    end
    check("nominal_no_underrun", 32'(bus.underrun), 32'd0);

    // Source stalls from payload symbol 3 onward
    start_frame(2, 1, 1 + SPS * (NP + 3), 1'b0);
    run(TOTAL + 5);
    check_frame("stall");
    check("stall_underrun_sticky", 32'(bus.underrun), 32'd1);
    for (int k = NP + 4; k < NP + NL; k++)
      if (obs_syms.size() > k) check("stall_payload_zero", 32'(obs_syms[k]), 32'd0);

    // Mid-preamble reset abort, then a full frame
    start_frame(1, 1, 0, 1'b0);
    check("start_clears_underrun", 32'(bus.underrun), 32'd0);
    run(49);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(dut_outs()), 32'd0);
    run(3);
    rst = 1'b0;
    run(5);
    check("abort_no_frame_done", 32'(fd_times.size()), 32'd0);
    start_frame(1, 1, 0, 1'b0);
    run(TOTAL + 5);
    check_frame("after_abort");

    // start held high: back-to-back frames, one IDLE cycle apart
    start_frame(1, 1, 0, 1'b1);
    run(3 * (TOTAL + 1) + 17);
    check("held_frame_done_count", 32'(fd_times.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (fd_times.size() > i) check("held_frame_done_cycle", 32'(fd_times[i]), 32'((i + 1) * (TOTAL + 1)));
    bus.start = 1'b0;
    run(TOTAL + 5);

    // Random source frames
    repeat (3) begin
      start_frame(1, 1, 0, 1'b0);
      run(TOTAL + 3 + $urandom_range(4));
      check_frame("random");
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
